ppi_access_arbiter: RTL and testbench
=====================================

# ppi_access_arbiter

Two-port arbiter and bus sequencer in front of the 8255 PPI. It shares the PPI register interface between the Z80 I/O path (CPU port) and a host/OSD helper (AUX port), such as a snapshot loader or keyboard injector. It generates clean `cs`/`we`/`oe` cycles: each write appears to the PPI as exactly one rising edge of `we`, preceded by at least one cycle of `we` low. Read data is captured and returned with a one-cycle acknowledge.

## Interface
Parameters:
- `GAP_CYCLES`, default 1: idle cycles inserted after each transaction, range 0–15.
- `AUX_FIRST`, default 0: 1 gives AUX the first grant after reset; 0 gives CPU the first grant.

Ports (clock and reset first):
- `clk_sys`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  CPU transaction request; held until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  2  PPI register: 0 = A, 1 = B, 2 = C, 3 = control.
- `cpu_wdata`  in  8  write data.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  8  read data; valid while `cpu_ack` = 1, then held.
- `aux_req`, `aux_we`, `aux_addr[1:0]`, `aux_wdata[7:0]`, `aux_ack`, `aux_rdata[7:0]`: same definitions as the CPU port.
- `ppi_cs`  out  1  PPI chip select.
- `ppi_we`  out  1  PPI write strobe.
- `ppi_oe`  out  1  PPI read enable.
- `ppi_addr`  out  2  PPI register address.
- `ppi_idata`  out  8  data to the PPI.
- `ppi_odata`  in  8  data from the PPI; combinational from `ppi_addr`, `ppi_cs`, `ppi_oe`.
- `busy`  out  1  high in any state other than IDLE.
- `mode_shadow`  out  8  present only with `PPI_ARB_SHADOW_EN`.

## Operation
- FSM states: IDLE → SETUP → STROBE → DONE → GAP → IDLE. GAP is skipped when `GAP_CYCLES` = 0.
- **IDLE**
  - If either `req` is high, choose a winner.
  - If both are high, use round-robin: the winner is the port not granted last.
  - Latch the winner's `we`, `addr` and `wdata` into internal registers, then go to SETUP.
- **SETUP**
  - `ppi_cs` = 1; `ppi_addr` and `ppi_idata` driven from the latched values.
  - `ppi_we` = 0 and `ppi_oe` = 0.
- **STROBE**
  - `ppi_cs` = 1.
  - Write: `ppi_we` = 1.
  - Read: `ppi_oe` = 1; `ppi_odata` is registered into the winner's `rdata` at the end of this cycle.
- **DONE**
  - `ppi_we`, `ppi_oe` and `ppi_cs` return to 0.
  - The winner's `ack` = 1 for this one cycle.
  - For a write, the winner's `rdata` is unchanged.
- **GAP**: a down-counter runs for `GAP_CYCLES` cycles with all PPI strobes low, then returns to IDLE.
- The latched request is authoritative. Dropping `req` or changing inputs after IDLE does not abort the transaction, and `ack` still pulses.
- A port whose `req` is still high after its `ack` is a new request and competes in the next IDLE.
- `ppi_addr` and `ppi_idata` hold their last values outside SETUP/STROBE.

## Timing
- Reset values:
  - FSM = IDLE.
  - `ppi_cs`/`ppi_we`/`ppi_oe` = 0; `ppi_addr` = 0; `ppi_idata` = 0x00.
  - `cpu_ack`/`aux_ack` = 0; `cpu_rdata`/`aux_rdata` = 0x00; `busy` = 0.
  - Last-grant register = the port opposite to the one `AUX_FIRST` selects.
- Latency: if `req` is sampled high in IDLE at edge N, SETUP runs in cycle N+1, STROBE in N+2, and `ack` is high in N+3.
- Throughput: one transaction every 4 + `GAP_CYCLES` cycles, counting the IDLE cycle.
- `ppi_we` is high for exactly one cycle per write and is always preceded by a low cycle, so the PPI's edge detector sees exactly one edge.
- Asserting `reset_n` low mid-transaction:
  - All outputs go to their reset values immediately.
  - The in-flight transaction is dropped and no `ack` is issued.
  - A partially issued PPI cycle is not replayed.
- Both requests rising in the same cycle: resolved by round-robin with no lost request; the loser is served next, at the earliest 4 + `GAP_CYCLES` cycles later.

## Configuration
- `PPI_ARB_SHADOW_EN` defined:
  - Adds an 8-bit `mode_shadow` register, reset to 0x9B.
  - It is updated in DONE on any write to address 3 with data bit 7 = 1 (mode word).
  - Bit-set/reset words (bit 7 = 0) leave it unchanged.
  - Writes from either port update it.
  - Used by the OSD snapshot logic, since the mode register cannot be read back through port C semantics.
- Undefined: the `mode_shadow` port and register are absent; all other behaviour is identical.

## Test plan
- CPU write: addr 0, data 0x5A, `GAP_CYCLES` = 1 → `ppi_we` high for exactly one cycle, with `ppi_addr` = 0 and `ppi_idata` = 0x5A; `cpu_ack` 3 cycles after the request edge; `busy` low 5 cycles after the request edge.
- AUX read: addr 1 with the PPI model returning 0xC3 → `ppi_oe` = 1 only in STROBE; `aux_rdata` = 0xC3 while `aux_ack` = 1; `cpu_rdata` stays 0x00.
- Both ports request in the same cycle, `AUX_FIRST` = 0 → CPU served first, then AUX; `aux_ack` 4 + `GAP_CYCLES` cycles after `cpu_ack`. Repeat with both held high → acks alternate CPU/AUX.
- `reset_n` pulsed low during STROBE of a write → `ppi_we`/`ppi_cs` drop asynchronously; no `ack`; FSM in IDLE on release.
- `GAP_CYCLES` = 0, back-to-back CPU writes to addr 2 (0x01, then 0x02) → two distinct `ppi_we` pulses separated by at least 2 low cycles; PPI port C receives both.
- With `PPI_ARB_SHADOW_EN`: write 0x82 to addr 3 → `mode_shadow` = 0x82; then write 0x07 to addr 3 → `mode_shadow` stays 0x82.

Source files
------------

// File: rtl/ppi_access_arbiter_if.sv
// ppi_access_arbiter_if: CPU/AUX request ports and 8255 PPI register bus shared by the arbiter.
interface ppi_access_arbiter_if;
  logic       cpu_req, cpu_we, cpu_ack;
  logic [1:0] cpu_addr;
  logic [7:0] cpu_wdata, cpu_rdata;
  logic       aux_req, aux_we, aux_ack;
  logic [1:0] aux_addr;
  logic [7:0] aux_wdata, aux_rdata;
  logic       ppi_cs, ppi_we, ppi_oe;
  logic [1:0] ppi_addr;
  logic [7:0] ppi_idata, ppi_odata;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, aux_req, aux_we, aux_addr, aux_wdata, ppi_odata,
    output cpu_ack, cpu_rdata, aux_ack, aux_rdata, ppi_cs, ppi_we, ppi_oe, ppi_addr, ppi_idata
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, aux_req, aux_we, aux_addr, aux_wdata, ppi_odata,
    input  cpu_ack, cpu_rdata, aux_ack, aux_rdata, ppi_cs, ppi_we, ppi_oe, ppi_addr, ppi_idata
  );
endinterface

// File: rtl/ppi_access_arbiter.sv
// ppi_access_arbiter: round-robin CPU/AUX arbiter issuing clean cs/we/oe cycles to an 8255 PPI.
// Define PPI_ARB_SHADOW_EN to add the mode_shadow register tracking the last mode word.
module ppi_access_arbiter #(
  parameter int GAP_CYCLES = 1,
  parameter bit AUX_FIRST  = 1'b0
) (
  input  logic clk_sys,
  input  logic reset_n,
  ppi_access_arbiter_if.slave bus,
  output logic busy
`ifdef PPI_ARB_SHADOW_EN
  ,
  output logic [7:0] mode_shadow
`endif
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, DONE, GAP} state_t;
  state_t     r_state, w_next;
  logic       r_grant, r_we;
  logic [1:0] r_addr;
  logic [7:0] r_wdata, r_cpu_rdata, r_aux_rdata;
  logic [3:0] r_gap;
  logic       w_start, w_win;
  // r_grant: 1 = AUX owns the current (or most recent) transaction
  assign w_start = bus.cpu_req | bus.aux_req;
  assign w_win   = (bus.cpu_req & bus.aux_req) ? ~r_grant : bus.aux_req;
  assign busy    = r_state != IDLE;
  assign bus.ppi_addr  = r_addr;
  assign bus.ppi_idata = r_wdata;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.aux_rdata = r_aux_rdata;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_start ? SETUP : IDLE;
      SETUP:   w_next = STROBE;
      STROBE:  w_next = DONE;
      DONE:    w_next = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:     w_next = (r_gap == 4'd0) ? IDLE : GAP;
      default: w_next = IDLE;
    endcase
    bus.ppi_cs  = (r_state == SETUP) || (r_state == STROBE);
    bus.ppi_we  = (r_state == STROBE) && r_we;
    bus.ppi_oe  = (r_state == STROBE) && !r_we;
    bus.cpu_ack = (r_state == DONE) && !r_grant;
    bus.aux_ack = (r_state == DONE) && r_grant;
  end
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_grant     <= ~AUX_FIRST;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_aux_rdata <= '0;
      r_gap       <= '0;
    end else begin
      if (r_state == IDLE && w_start) begin
        r_grant <= w_win;
        r_we    <= w_win ? bus.aux_we : bus.cpu_we;
        r_addr  <= w_win ? bus.aux_addr : bus.cpu_addr;
        r_wdata <= w_win ? bus.aux_wdata : bus.cpu_wdata;
      end
      if (r_state == STROBE && !r_we && !r_grant) r_cpu_rdata <= bus.ppi_odata;
      if (r_state == STROBE && !r_we && r_grant) r_aux_rdata <= bus.ppi_odata;
      r_gap <= (r_state == DONE) ? 4'(GAP_CYCLES - 1) : r_gap - 4'd1;
    end
  end
`ifdef PPI_ARB_SHADOW_EN
  logic [7:0] r_shadow;
  assign mode_shadow = r_shadow;
  // only mode words (bit 7 set) to the control register; bit-set/reset words are ignored
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) r_shadow <= 8'h9B;
    else if (r_state == DONE && r_we && r_addr == 2'd3 && r_wdata[7]) r_shadow <= r_wdata;
`endif
endmodule

// File: tb/tb_ppi_access_arbiter.sv
// tb_ppi_access_arbiter: directed scoreboard bench for ppi_access_arbiter (GAP_CYCLES 1 and 0 instances).
module tb_ppi_access_arbiter;
  typedef struct {logic port; logic [7:0] rd; int cyc;} ack_t;
  typedef struct {logic [1:0] a; logic [7:0] d;} wr_t;
  logic clk, reset_n, busy0, busy1;
  logic [7:0] shadow0, shadow1;
  logic [7:0] m0 [4];
  logic [7:0] m1 [4];
  int cyc = 0, n_cmp = 0, n_err = 0, k, lw1 = -1;
  logic we0_prev = 1'b0, oe0_prev = 1'b0, we1_prev = 1'b0;
  ack_t q0_ack[$], q1_ack[$], e0, e1;
  wr_t  q0_wr[$], q1_wr[$], w0, w1;
  ppi_access_arbiter_if b0();
  ppi_access_arbiter_if b1();
  ppi_access_arbiter #(.GAP_CYCLES(1), .AUX_FIRST(1'b0)) u0 (
    .clk_sys(clk), .reset_n(reset_n), .bus(b0), .busy(busy0)
`ifdef PPI_ARB_SHADOW_EN
    , .mode_shadow(shadow0)
`endif
  );
  ppi_access_arbiter #(.GAP_CYCLES(0), .AUX_FIRST(1'b0)) u1 (
    .clk_sys(clk), .reset_n(reset_n), .bus(b1), .busy(busy1)
`ifdef PPI_ARB_SHADOW_EN
    , .mode_shadow(shadow1)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // PPI register models: writes land on the edge ending STROBE, reads are combinational
  assign b0.ppi_odata = (b0.ppi_cs && b0.ppi_oe) ? m0[b0.ppi_addr] : 8'hFF;
  assign b1.ppi_odata = (b1.ppi_cs && b1.ppi_oe) ? m1[b1.ppi_addr] : 8'hFF;
  always @(posedge clk) if (b0.ppi_we) m0[b0.ppi_addr] <= b0.ppi_idata;
  always @(posedge clk) if (b1.ppi_we) m1[b1.ppi_addr] <= b1.ppi_idata;

  function automatic void cmp(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (b0.cpu_ack || b0.aux_ack) begin
      cmp("u0_single_ack", {31'd0, b0.cpu_ack & b0.aux_ack}, 0);
      if (q0_ack.size() == 0) cmp("u0_unexpected_ack", 1, 0);
      else begin
        e0 = q0_ack.pop_front();
        cmp("u0_ack_port", {31'd0, b0.aux_ack}, {31'd0, e0.port});
        cmp("u0_ack_rdata", {24'd0, e0.port ? b0.aux_rdata : b0.cpu_rdata}, {24'd0, e0.rd});
        cmp("u0_ack_cycle", cyc, e0.cyc);
      end
    end
    if (b0.ppi_we && !we0_prev) begin
      if (q0_wr.size() == 0) cmp("u0_unexpected_we", 1, 0);
      else begin
        w0 = q0_wr.pop_front();
        cmp("u0_we_addr", {30'd0, b0.ppi_addr}, {30'd0, w0.a});
        cmp("u0_we_data", {24'd0, b0.ppi_idata}, {24'd0, w0.d});
        cmp("u0_we_cs", {31'd0, b0.ppi_cs}, 1);
      end
    end
    if (b0.ppi_we && we0_prev) cmp("u0_we_width", 2, 1);
    if (b0.ppi_oe) cmp("u0_oe_cs_we", {30'd0, b0.ppi_cs, b0.ppi_we}, 2);
    if (b0.ppi_oe && oe0_prev) cmp("u0_oe_width", 2, 1);
    we0_prev = b0.ppi_we;
    oe0_prev = b0.ppi_oe;
  end

  always @(negedge clk) begin
    if (b1.cpu_ack || b1.aux_ack) begin
      if (q1_ack.size() == 0) cmp("u1_unexpected_ack", 1, 0);
      else begin
        e1 = q1_ack.pop_front();
        cmp("u1_ack_port", {31'd0, b1.aux_ack}, {31'd0, e1.port});
        cmp("u1_ack_cycle", cyc, e1.cyc);
      end
    end
    if (b1.ppi_we && !we1_prev) begin
      if (q1_wr.size() == 0) cmp("u1_unexpected_we", 1, 0);
      else begin
        w1 = q1_wr.pop_front();
        cmp("u1_we_addr", {30'd0, b1.ppi_addr}, {30'd0, w1.a});
        cmp("u1_we_data", {24'd0, b1.ppi_idata}, {24'd0, w1.d});
      end
      if (lw1 >= 0) cmp("u1_we_low_gap", cyc - lw1 - 1, 3);
      lw1 = cyc;
    end
    if (b1.ppi_we && we1_prev) cmp("u1_we_width", 2, 1);
    we1_prev = b1.ppi_we;
  end

  task automatic wait_idle();
    int t = 0;
    while (busy0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    cmp("u0_idle_reached", {31'd0, busy0}, 0);
  endtask

  task automatic run(input int nc, input int na);
    int cc = 0, ca = 0, t = 0;
    while ((cc < nc || ca < na) && t < 40) begin
      @(negedge clk);
      t++;
      if (b0.cpu_ack) begin
        cc++;
        if (cc >= nc) b0.cpu_req = 1'b0;
      end
      if (b0.aux_ack) begin
        ca++;
        if (ca >= na) b0.aux_req = 1'b0;
      end
    end
    cmp("run_cpu_acks", cc, nc);
    cmp("run_aux_acks", ca, na);
  endtask

  task automatic cpu_set(input logic we, input logic [1:0] a, input logic [7:0] d);
    b0.cpu_we = we; b0.cpu_addr = a; b0.cpu_wdata = d; b0.cpu_req = 1'b1;
  endtask

  task automatic aux_set(input logic we, input logic [1:0] a, input logic [7:0] d);
    b0.aux_we = we; b0.aux_addr = a; b0.aux_wdata = d; b0.aux_req = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    m0[0] = 8'h00; m0[1] = 8'hC3; m0[2] = 8'h00; m0[3] = 8'h00;
    m1[0] = 8'h00; m1[1] = 8'h00; m1[2] = 8'h00; m1[3] = 8'h00;
    reset_n = 1'b0;
    b0.cpu_req = 0; b0.cpu_we = 0; b0.cpu_addr = 0; b0.cpu_wdata = 0;
    b0.aux_req = 0; b0.aux_we = 0; b0.aux_addr = 0; b0.aux_wdata = 0;
    b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = 0; b1.cpu_wdata = 0;
    b1.aux_req = 0; b1.aux_we = 0; b1.aux_addr = 0; b1.aux_wdata = 0;
    repeat (3) @(negedge clk);
    cmp("rst_strobes", {29'd0, b0.ppi_cs, b0.ppi_we, b0.ppi_oe}, 0);
    cmp("rst_ppi_addr", {30'd0, b0.ppi_addr}, 0);
    cmp("rst_ppi_idata", {24'd0, b0.ppi_idata}, 0);
    cmp("rst_acks", {30'd0, b0.cpu_ack, b0.aux_ack}, 0);
    cmp("rst_rdata", {16'd0, b0.cpu_rdata, b0.aux_rdata}, 0);
    cmp("rst_busy", {30'd0, busy0, busy1}, 0);
`ifdef PPI_ARB_SHADOW_EN
    cmp("rst_shadow", {24'd0, shadow0}, 32'h9B);
`endif
    reset_n = 1'b1;
    // CPU write, latency and busy window
    wait_idle();
    k = cyc;
    cpu_set(1'b1, 2'd0, 8'h5A);
    q0_ack.push_back('{1'b0, 8'h00, k + 3});
    q0_wr.push_back('{2'd0, 8'h5A});
    run(1, 0);
    @(negedge clk);
    cmp("busy_4_after", {31'd0, busy0}, 1);
    @(negedge clk);
    cmp("busy_5_after", {31'd0, busy0}, 0);
    // AUX read returns the modelled register B value
    wait_idle();
    k = cyc;
    aux_set(1'b0, 2'd1, 8'h00);
    q0_ack.push_back('{1'b1, 8'hC3, k + 3});
    run(0, 1);
    cmp("cpu_rdata_untouched", {24'd0, b0.cpu_rdata}, 0);
    @(negedge clk);
    cmp("aux_rdata_held", {24'd0, b0.aux_rdata}, 32'hC3);
    // simultaneous requests: CPU first, AUX 5 cycles later
    wait_idle();
    k = cyc;
    cpu_set(1'b1, 2'd2, 8'h11);
    aux_set(1'b0, 2'd0, 8'h00);
    q0_ack.push_back('{1'b0, 8'h00, k + 3});
    q0_ack.push_back('{1'b1, 8'h5A, k + 8});
    q0_wr.push_back('{2'd2, 8'h11});
    run(1, 1);
    // both held high: grants alternate
    wait_idle();
    k = cyc;
    cpu_set(1'b1, 2'd0, 8'h22);
    aux_set(1'b1, 2'd1, 8'h33);
    q0_ack.push_back('{1'b0, 8'h00, k + 3});
    q0_ack.push_back('{1'b1, 8'h5A, k + 8});
    q0_ack.push_back('{1'b0, 8'h00, k + 13});
    q0_ack.push_back('{1'b1, 8'h5A, k + 18});
    q0_wr.push_back('{2'd0, 8'h22});
    q0_wr.push_back('{2'd1, 8'h33});
    q0_wr.push_back('{2'd0, 8'h22});
    q0_wr.push_back('{2'd1, 8'h33});
    run(2, 2);
    // reset during STROBE of a write: strobes drop at once, no ack follows
    wait_idle();
    cpu_set(1'b1, 2'd0, 8'h99);
    q0_wr.push_back('{2'd0, 8'h99});
    repeat (2) @(negedge clk);
    cmp("strobe_we_high", {31'd0, b0.ppi_we}, 1);
    #2 reset_n = 1'b0;
    #1;
    cmp("async_rst_we_cs", {30'd0, b0.ppi_we, b0.ppi_cs}, 0);
    cmp("async_rst_busy", {31'd0, busy0}, 0);
    b0.cpu_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    cmp("post_rst_idle", {31'd0, busy0}, 0);
    cmp("post_rst_aux_rdata", {24'd0, b0.aux_rdata}, 0);
    // control-register writes: mode word, then bit-set/reset word
    wait_idle();
    k = cyc;
    cpu_set(1'b1, 2'd3, 8'h82);
    q0_ack.push_back('{1'b0, 8'h00, k + 3});
    q0_wr.push_back('{2'd3, 8'h82});
    run(1, 0);
    @(negedge clk);
`ifdef PPI_ARB_SHADOW_EN
    cmp("shadow_mode_word", {24'd0, shadow0}, 32'h82);
`endif
    wait_idle();
    k = cyc;
    cpu_set(1'b1, 2'd3, 8'h07);
    q0_ack.push_back('{1'b0, 8'h00, k + 3});
    q0_wr.push_back('{2'd3, 8'h07});
    run(1, 0);
    @(negedge clk);
`ifdef PPI_ARB_SHADOW_EN
    cmp("shadow_bsr_ignored", {24'd0, shadow0}, 32'h82);
`endif
    // GAP_CYCLES=0 instance: back-to-back writes to port C
    k = cyc;
    b1.cpu_we = 1'b1; b1.cpu_addr = 2'd2; b1.cpu_wdata = 8'h01; b1.cpu_req = 1'b1;
    q1_ack.push_back('{1'b0, 8'h00, k + 3});
    q1_ack.push_back('{1'b0, 8'h00, k + 7});
    q1_wr.push_back('{2'd2, 8'h01});
    q1_wr.push_back('{2'd2, 8'h02});
    n = 0;
    for (int t = 0; t < 40 && n < 2; t++) begin
      @(negedge clk);
      if (b1.cpu_ack) begin
        n++;
        if (n == 1) b1.cpu_wdata = 8'h02;
        else b1.cpu_req = 1'b0;
      end
    end
    cmp("gap0_acks", n, 2);
    repeat (2) @(negedge clk);
    cmp("gap0_portc_final", {24'd0, m1[2]}, 32'h02);
    repeat (3) @(negedge clk);
    cmp("q0_ack_drained", q0_ack.size(), 0);
    cmp("q0_wr_drained", q0_wr.size(), 0);
    cmp("q1_ack_drained", q1_ack.size(), 0);
    cmp("q1_wr_drained", q1_wr.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
